aes128_cipher_packer: RTL
=========================

AES128_CIPHER_PACKER -- requirements
Module: aes128_cipher_packer

Interface
REQ-001 SHALL have parameter PAD_BYTE, default 8'h00: fill value for the unfilled bytes of a short final block.
REQ-002 SHALL have parameter CORE_LATENCY, default 41: cycles from a cipherText update until aes128_decryption presents the matching plainText.
REQ-003 SHALL have port clk, input, 1: single clock; all state on rising edge.
REQ-004 SHALL have port rst, input, 1: reset; asynchronous, active-low.
REQ-005 SHALL have port in_byte, input, 8: ciphertext byte stream.
REQ-006 SHALL have port in_valid, input, 1: in_byte valid.
REQ-007 SHALL have port in_last, input, 1: qualified by in_valid; the byte is the last of the message.
REQ-008 SHALL have port in_ready, output, 1: a byte is accepted on an edge where in_valid and in_ready are both 1.
REQ-009 SHALL have port cipherText, output, 128: assembled block; drives aes128_decryption cipherText.
REQ-010 SHALL have port ct_valid, output, 1: one-cycle strobe marking a new cipherText.
REQ-011 SHALL have port blk_cnt, output, 16: count of blocks emitted.
REQ-012 SHALL have port pt_valid, output, 1: the aligned plainText of the core is valid this cycle.

Function
REQ-013 SHALL place the first accepted byte of a block in bits [127:120] and the 16th in [7:0] (big-endian, matching hex literal order).
REQ-014 SHALL use a 4-bit byte index (0..15) that wraps to 0 after the 16th byte.
REQ-015 SHALL use FSM states FILL and PAD; FILL is the reset state, and in_ready is 1 in FILL and 0 in PAD.
REQ-016 SHALL, on the edge that accepts byte index 15 in FILL, load cipherText with the full block, set ct_valid=1 for exactly one cycle, increment blk_cnt, and set index to 0.
REQ-017 SHALL keep cipherText stable between strobes.
REQ-018 SHALL hold a separate assembly register so that in FILL a new block can begin on the edge after an emit (no bubble); sustained throughput is one block per 16 cycles.
REQ-019 SHALL, when in_last is accepted at index 15, emit normally and stay in FILL.
REQ-020 SHALL, when in_last is accepted at index i<15, enter PAD and write PAD_BYTE into one byte per cycle for 15-i cycles.
REQ-021 SHALL, in PAD, emit on the edge that writes index 15 (per REQ-016) and return to FILL.
REQ-022 SHALL ignore in_last when in_valid=0.
REQ-023 SHALL wrap blk_cnt from 16'hFFFF to 16'h0000 silently.

Reset
REQ-024 SHALL, on rst=0, immediately (asynchronously) set cipherText=0, ct_valid=0, blk_cnt=0, pt_valid=0, index=0, state=FILL, the assembly register to 0, and the valid delay line to 0.
REQ-025 SHALL discard any partial block on reset mid-operation, including a reset during PAD; in_ready SHALL read 1 while rst=0.

Configuration
REQ-026 SHALL, when macro AES_VALID_TRACK_EN is defined, generate pt_valid as ct_valid delayed by exactly CORE_LATENCY cycles through a CORE_LATENCY-bit shift register.
REQ-027 SHALL, when AES_VALID_TRACK_EN is undefined, omit the shift register and tie pt_valid to 0.

Structure
REQ-028 SHALL take the FSM state typedef, the block width (128) and the bytes-per-block constant (16) from shared package aes128_pkg.
REQ-029 SHALL implement the delay line as sub-module aes128_valid_delay, parameterised by its length and instantiated only under AES_VALID_TRACK_EN.

Verification
REQ-030 SHALL verify a full block: bytes 4d 80 f1 06 3d 5e 5c 7b 09 ee 40 7b 11 53 b4 ee, one per cycle -> cipherText=4d80f1063d5e5c7b09ee407b1153b4ee with ct_valid high for one cycle after the 16th edge, and blk_cnt=1.
REQ-031 SHALL verify back-to-back blocks: 16 bytes of 59fc458cc22dce9193006fd01153e8f7 immediately after REQ-030's block -> second strobe exactly 16 cycles after the first, in_ready constantly 1, and blk_cnt=2.
REQ-032 SHALL verify a short block: PAD_BYTE=8'h20, bytes 74 68 65 20 6c 61 7a 79 20 64 6f 67 2e with in_last on 2e -> in_ready=0 for 3 cycles, then cipherText=746865206c617a7920646f672e202020 with one strobe.
REQ-033 SHALL verify valid tracking: with AES_VALID_TRACK_EN and CORE_LATENCY=41 -> pt_valid pulses exactly 41 cycles after each ct_valid; without the macro -> pt_valid is always 0.
REQ-034 SHALL verify reset mid-block: 7 bytes accepted, rst low for 1 cycle, then the 16 bytes of REQ-030 -> single emit of 4d80f1063d5e5c7b09ee407b1153b4ee with no residue, and blk_cnt=1.
REQ-035 SHALL verify counter wrap: force blk_cnt=16'hFFFF, then emit one block -> blk_cnt=0.

Source files
------------

// File: rtl/aes128_pkg.sv
// Shared types and constants for the AES-128 ciphertext packer.
// Holds the FSM state type, the block geometry and a byte-insert helper.
package aes128_pkg;

   localparam int BLOCK_W     = 128;
   localparam int BLOCK_BYTES = 16;
   localparam logic [3:0] LAST_IDX = 4'(BLOCK_BYTES - 1);

   typedef enum logic {
      FILL = 1'b0,
      PAD  = 1'b1
   } state_t;

   // Index 0 lands in the top byte so the block reads like a hex literal.
   function automatic logic [BLOCK_W-1:0] put_byte(input logic [BLOCK_W-1:0] blk,
                                                   input logic [3:0]         idx,
                                                   input logic [7:0]         data);
      logic [BLOCK_W-1:0] res;
      res = blk;
      res[(BLOCK_BYTES - 1 - int'(idx)) * 8 +: 8] = data;
      return res;
   endfunction

endpackage

// File: rtl/aes128_valid_delay.sv
// Fixed-length valid delay line: dout follows din LENGTH cycles later.
// Used to line up the packer strobe with the decryption core's output.
module aes128_valid_delay #(
   parameter int LENGTH = 41
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic dout
);

   logic [LENGTH-1:0] shift;

   // Shift the strobe one stage per clock; cleared asynchronously on reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         shift <= '0;
      end else begin
         shift <= (shift << 1) | LENGTH'(din);
      end
   end

   assign dout = shift[LENGTH-1];

endmodule

// File: rtl/aes128_cipher_packer.sv
// Packs a ciphertext byte stream into 128-bit blocks for aes128_decryption.
// A short final block is padded with PAD_BYTE, one byte per cycle.
// Optional macro AES_VALID_TRACK_EN adds a CORE_LATENCY-deep delay line
// that produces pt_valid aligned with the core's plainText.
//
// state | meaning
// FILL  | accepting bytes from the stream (in_ready = 1)
// PAD   | filling the rest of a short block with PAD_BYTE (in_ready = 0)
module aes128_cipher_packer
   import aes128_pkg::*;
#(
   parameter logic [7:0] PAD_BYTE     = 8'h00,
   parameter int         CORE_LATENCY = 41
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [7:0]         in_byte,
   input  logic               in_valid,
   input  logic               in_last,
   output logic               in_ready,
   output logic [BLOCK_W-1:0] cipherText,
   output logic               ct_valid,
   output logic [15:0]        blk_cnt,
   output logic               pt_valid
);

   if (CORE_LATENCY < 1) begin : g_bad_latency
      $error("aes128_cipher_packer: CORE_LATENCY must be at least 1");
   end

   state_t             state;
   logic [3:0]         idx;
   logic [BLOCK_W-1:0] asm_blk;
   logic               accept;
   logic               write;
   logic [7:0]         wr_byte;
   logic [BLOCK_W-1:0] next_blk;

   assign in_ready = (state == FILL);
   assign accept   = (state == FILL) && in_valid;
   assign write    = accept || (state == PAD);

   // Byte written this cycle: stream data while filling, pad value otherwise.
   always_comb begin
      wr_byte  = (state == PAD) ? PAD_BYTE : in_byte;
      next_blk = put_byte(asm_blk, idx, wr_byte);
   end

   // Assembly, emit and FSM; the emitted block is copied out so the
   // assembly register is free to start the next block on the following edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= FILL;
         idx        <= '0;
         asm_blk    <= '0;
         cipherText <= '0;
         ct_valid   <= 1'b0;
         blk_cnt    <= '0;
      end else begin
         ct_valid <= 1'b0;
         if (write) begin
            asm_blk <= next_blk;
            if (idx == LAST_IDX) begin
               cipherText <= next_blk;
               ct_valid   <= 1'b1;
               blk_cnt    <= blk_cnt + 16'd1;
               idx        <= '0;
               state      <= FILL;
            end else begin
               idx <= idx + 4'd1;
               if (accept && in_last) begin
                  state <= PAD;
               end
            end
         end
      end
   end

`ifdef AES_VALID_TRACK_EN
   aes128_valid_delay #(
      .LENGTH (CORE_LATENCY)
   ) u_valid_delay (
      .clk  (clk),
      .rst  (rst),
      .din  (ct_valid),
      .dout (pt_valid)
   );
`else
   assign pt_valid = 1'b0;
`endif

endmodule
